painterengine_gpu_fill_source: RTL and testbench
================================================

Name: painterengine_gpu_fill_source

Overview:
- Pixel stream generator sitting directly upstream of one channel of the GPU DMA writer.
- Produces `length` 32-bit pixels: either a solid colour, or a per-row horizontal gradient with per-byte-channel arithmetic.
- Pixels pass through an internal FIFO and are presented on a valid/next interface. `next` is the writer's combinational accept strobe.
- Reports done when the last pixel has been accepted, and a sticky error with type code on bad parameters or protocol misuse.

Parameters:
- PARAM_FIFO_DEPTH, 8, FIFO entries; power of two, 2..256.
- PARAM_FIFO_AW, 3, log2(PARAM_FIFO_DEPTH); pointer width.

Ports:
- i_wire_clock  in  1  clock.
- i_wire_resetn  in  1  reset: asynchronous, active-low.
- i_wire_start  in  1  one-cycle pulse; latches parameters, starts a job.
- i_wire_abort  in  1  synchronous abort; flushes FIFO, returns to IDLE.
- i_wire_mode  in  1  0 = solid fill, 1 = horizontal gradient.
- i_wire_color  in  32  base pixel value.
- i_wire_step  in  32  per-pixel increment, four independent byte channels.
- i_wire_width  in  16  row width in pixels (gradient mode only).
- i_wire_length  in  32  total pixel count.
- o_wire_data  out  32  FIFO head pixel.
- o_wire_data_valid  out  1  FIFO non-empty.
- i_wire_data_next  in  1  consumer accepted o_wire_data this cycle.
- o_wire_busy  out  1  state is RUN or DRAIN.
- o_wire_done  out  1  state is DONE.
- o_wire_error  out  1  state is ERROR.
- o_wire_error_type  out  2  0 ok, 1 zero length, 2 zero width in gradient mode, 3 next while not valid.

Behaviour:
- Reset values:
  - State IDLE; FIFO empty; all counters 0.
  - o_wire_data = 0, o_wire_data_valid = 0, busy/done/error = 0, error_type = 0.
- States: IDLE, RUN, DRAIN, DONE, ERROR.
- IDLE/DONE + start:
  - Latch mode, color, step, width, length.
  - length == 0 → ERROR, type 1.
  - mode == 1 and width == 0 → ERROR, type 2.
  - Otherwise → RUN. Generated count = 0, popped count = 0, column = 0, accumulator = color.
- Start while RUN/DRAIN is ignored.
- DONE holds until the next start or an abort.
- RUN:
  - Each cycle with FIFO not full at cycle start: push one pixel, increment generated count.
  - There is no push-through-pop bypass when full.
  - When generated count reaches length, go to DRAIN.
- Pixel value:
  - Solid mode: color.
  - Gradient mode: each byte channel k holds (color[k] + step[k] * column) mod 256, with no carry between bytes.
  - Implement incrementally: per-byte accumulator += step byte.
  - On column == width-1: column → 0 and accumulator → color.
- Pop:
  - next && valid removes the head. Pop and push in the same cycle are both allowed; occupancy is unchanged.
  - The new head appears on o_wire_data the cycle after a pop.
  - o_wire_data is combinational from the head entry and is 0 when empty.
- DRAIN: when the popped count reaches length (the pop of the last pixel), go to DONE on the next edge.
- Protocol misuse: next asserted while valid == 0 in RUN/DRAIN → ERROR, type 3. next in IDLE/DONE is ignored.
- ERROR:
  - Sticky; FIFO is flushed; valid = 0.
  - Left only by reset or abort (→ IDLE, error_type cleared).
- Abort:
  - Takes priority over start and pop in the same cycle.
  - Clears FIFO pointers and counters; state → IDLE.
- Width and wrap rules:
  - 32-bit counters; length up to 2^32-1.
  - FIFO pointers are PARAM_FIFO_AW+1 bits: full when the MSBs differ and the rest are equal.
  - Column counter is 16 bits.
- Throughput: with next held high, one pixel is accepted per cycle sustained after a 1-cycle start latency. The first valid appears 2 cycles after the start edge.

Test Plan:
- Solid fill: start, mode 0, color 0xFF00FF00, length 20, next held high → 20 accepted words all 0xFF00FF00, done 1 cycle after the 20th accept, no extra valid.
- Gradient: mode 1, color 0x00000010, step 0x00000105, width 4, length 10 → bytes[1:0] sequence 0x0010, 0x0115, 0x021A, 0x031F, then repeats from 0x0010; byte0 wraps mod 256 when step 0x000000F0 is used.
- Backpressure: next toggled randomly, length 100, DEPTH 8 → valid never drops while occupancy > 0, no pushes when full, order preserved, 100 words exact.
- Bad parameters: length 0 → error = 1, type 1; mode 1 with width 0 → type 2; abort → IDLE, error_type 0.
- Misuse: next while valid == 0 mid-RUN → ERROR, type 3, valid forced 0.
- Abort mid-job after 5 accepts, then new start with length 3 → exactly 3 fresh words, no stale FIFO data; start during RUN is ignored; async reset mid-DRAIN → all outputs 0 immediately.

Source files
------------

// File: rtl/painterengine_gpu_fill_source_if.sv
// Pixel stream link between the fill source and the DMA writer channel.
//   o_wire_data        FIFO head pixel (0 when empty)
//   o_wire_data_valid  FIFO non-empty
//   i_wire_data_next   consumer accepts the head this cycle (combinational strobe)
// master = pixel source, slave = consumer.
interface painterengine_gpu_fill_source_if;
  logic [31:0] o_wire_data;
  logic        o_wire_data_valid;
  logic        i_wire_data_next;

  modport master (output o_wire_data, output o_wire_data_valid, input i_wire_data_next);
  modport slave  (input o_wire_data, input o_wire_data_valid, output i_wire_data_next);
endinterface

// File: rtl/painterengine_gpu_fill_source.sv
// Pixel stream generator feeding one GPU DMA writer channel.
// Generates i_wire_length pixels, either a solid colour or a per-row horizontal
// gradient (four independent 8-bit channels, no carry between bytes), buffers
// them in a small FIFO and presents them on a valid/next stream.
// Ports:
//   i_wire_clock, i_wire_resetn   clock, asynchronous active-low reset
//   i_wire_start, i_wire_abort    job start pulse, synchronous abort
//   i_wire_mode/color/step/width/length  job parameters, latched on start
//   pix_if                        pixel stream (data, valid, next)
//   o_wire_busy/done/error        RUN|DRAIN / DONE / ERROR state flags
//   o_wire_error_type             0 ok, 1 zero length, 2 zero width, 3 next while empty
module painterengine_gpu_fill_source #(
  parameter int PARAM_FIFO_DEPTH = 8,
  parameter int PARAM_FIFO_AW    = 3
) (
  input  logic        i_wire_clock,
  input  logic        i_wire_resetn,
  input  logic        i_wire_start,
  input  logic        i_wire_abort,
  input  logic        i_wire_mode,
  input  logic [31:0] i_wire_color,
  input  logic [31:0] i_wire_step,
  input  logic [15:0] i_wire_width,
  input  logic [31:0] i_wire_length,
  painterengine_gpu_fill_source_if.master pix_if,
  output logic        o_wire_busy,
  output logic        o_wire_done,
  output logic        o_wire_error,
  output logic [1:0]  o_wire_error_type
);

  localparam int AW = PARAM_FIFO_AW;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE, S_ERROR} state_t;

  state_t          state_q, state_d;
  logic [1:0]      etype_q, etype_d;
  logic            busy_q, done_q, error_q;

  logic            mode_q;
  logic [3:0][7:0] color_q, step_q, acc_q, acc_inc;
  logic [15:0]     width_q, col_q;
  logic [31:0]     len_q, gen_q, pop_cnt_q;

  logic [AW:0]     wptr_q, rptr_q;
  logic [31:0]     mem_q [PARAM_FIFO_DEPTH];

  logic            empty, full, active, idle_or_done, start_ok, misuse, push, pop;
  logic [31:0]     pix;

  always_comb begin
    empty        = (wptr_q == rptr_q);
    // extra pointer bit distinguishes full from empty when indices match
    full         = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    active       = (state_q == S_RUN) || (state_q == S_DRAIN);
    idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
    start_ok     = idle_or_done && i_wire_start && !i_wire_abort;
    misuse       = active && pix_if.i_wire_data_next && empty;
    // push decision uses occupancy at cycle start: no bypass when full
    push         = (state_q == S_RUN) && !full && !misuse && !i_wire_abort;
    pop          = pix_if.i_wire_data_next && !empty && !i_wire_abort;
    pix          = mode_q ? acc_q : color_q;
    for (int k = 0; k < 4; k++) acc_inc[k] = acc_q[k] + step_q[k];
  end

  always_comb begin
    state_d = state_q;
    etype_d = etype_q;
    if (i_wire_abort) begin
      state_d = S_IDLE;
      etype_d = 2'd0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (i_wire_start) begin
          if (i_wire_length == 32'd0) begin
            state_d = S_ERROR;
            etype_d = 2'd1;
          end else if (i_wire_mode && (i_wire_width == 16'd0)) begin
            state_d = S_ERROR;
            etype_d = 2'd2;
          end else begin
            state_d = S_RUN;
            etype_d = 2'd0;
          end
        end
        S_RUN: begin
          if (misuse) begin
            state_d = S_ERROR;
            etype_d = 2'd3;
          end else if (push && (gen_q + 32'd1 == len_q)) state_d = S_DRAIN;
        end
        S_DRAIN: begin
          if (misuse) begin
            state_d = S_ERROR;
            etype_d = 2'd3;
          end else if (pop && (pop_cnt_q + 32'd1 == len_q)) state_d = S_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state_q   <= S_IDLE;
      etype_q   <= 2'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      mode_q    <= 1'b0;
      color_q   <= '0;
      step_q    <= '0;
      acc_q     <= '0;
      width_q   <= '0;
      col_q     <= '0;
      len_q     <= '0;
      gen_q     <= '0;
      pop_cnt_q <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
    end else begin
      state_q <= state_d;
      etype_q <= etype_d;
      busy_q  <= (state_d == S_RUN) || (state_d == S_DRAIN);
      done_q  <= (state_d == S_DONE);
      error_q <= (state_d == S_ERROR);

      if (start_ok) begin
        mode_q  <= i_wire_mode;
        color_q <= i_wire_color;
        step_q  <= i_wire_step;
        width_q <= i_wire_width;
        len_q   <= i_wire_length;
      end

      if (i_wire_abort || (state_d == S_ERROR)) begin
        wptr_q    <= '0;
        rptr_q    <= '0;
        gen_q     <= '0;
        pop_cnt_q <= '0;
        col_q     <= '0;
      end else begin
        if (start_ok) begin
          gen_q     <= '0;
          pop_cnt_q <= '0;
          col_q     <= '0;
          acc_q     <= i_wire_color;
        end
        if (push) begin
          wptr_q <= wptr_q + 1'b1;
          gen_q  <= gen_q + 32'd1;
          // row wrap restarts the gradient from the base colour
          if (col_q == width_q - 16'd1) begin
            col_q <= '0;
            acc_q <= color_q;
          end else begin
            col_q <= col_q + 16'd1;
            acc_q <= acc_inc;
          end
        end
        if (pop) begin
          rptr_q    <= rptr_q + 1'b1;
          pop_cnt_q <= pop_cnt_q + 32'd1;
        end
      end
    end
  end

  // storage needs no reset: reads are masked while the FIFO is empty
  always_ff @(posedge i_wire_clock) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= pix;
  end

  assign pix_if.o_wire_data       = empty ? 32'd0 : mem_q[rptr_q[AW-1:0]];
  assign pix_if.o_wire_data_valid = !empty;
  assign o_wire_busy              = busy_q;
  assign o_wire_done              = done_q;
  assign o_wire_error             = error_q;
  assign o_wire_error_type        = etype_q;

endmodule

// File: tb/tb_painterengine_gpu_fill_source.sv
module tb_painterengine_gpu_fill_source;
  logic        clk = 1'b0, rstn = 1'b0, start = 1'b0, abort = 1'b0, mode = 1'b0;
  logic        want = 1'b0, force_next = 1'b0;
  logic [31:0] color = '0, step = '0, length = '0;
  logic [15:0] width = '0;
  logic        busy, done, error;
  logic [1:0]  etype;

  painterengine_gpu_fill_source_if ifc();
  // consumer only strobes next on valid data, except when misuse is forced
  assign ifc.i_wire_data_next = force_next | (want & ifc.o_wire_data_valid);

  painterengine_gpu_fill_source #(.PARAM_FIFO_DEPTH(8), .PARAM_FIFO_AW(3)) dut (
    .i_wire_clock(clk), .i_wire_resetn(rstn), .i_wire_start(start), .i_wire_abort(abort),
    .i_wire_mode(mode), .i_wire_color(color), .i_wire_step(step), .i_wire_width(width),
    .i_wire_length(length), .pix_if(ifc), .o_wire_busy(busy), .o_wire_done(done),
    .o_wire_error(error), .o_wire_error_type(etype));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // reference job model
  bit          chk_en = 0, rnd_next = 0, prev_valid = 0, prev_acc = 0;
  logic        m_mode;
  logic [31:0] m_color, m_step;
  int          m_width, m_len, acc_cnt, cyc, first_valid_cyc, first_done_cyc;
  logic [31:0] got[$];

  function automatic logic [31:0] exp_pix(int i);
    logic [31:0] r;
    int c;
    if (!m_mode) return m_color;
    c = i % m_width;
    for (int k = 0; k < 4; k++) r[k*8 +: 8] = 8'(m_color[k*8 +: 8] + m_step[k*8 +: 8] * c);
    return r;
  endfunction

  always @(negedge clk) if (chk_en) begin
    cyc++;
    chk("done", {31'd0, done}, {31'd0, acc_cnt == m_len});
    chk("busy", {31'd0, busy}, {31'd0, acc_cnt != m_len});
    chk("error", {30'd0, error, 1'b0} | {30'd0, etype}, 32'd0);
    if (acc_cnt == m_len) chk("no_extra_valid", {31'd0, ifc.o_wire_data_valid}, 32'd0);
    if (prev_valid && !prev_acc) chk("valid_hold", {31'd0, ifc.o_wire_data_valid}, 32'd1);
    if (!ifc.o_wire_data_valid) chk("data_empty_zero", ifc.o_wire_data, 32'd0);
    if (ifc.o_wire_data_valid && first_valid_cyc == 0) first_valid_cyc = cyc;
    if (done && first_done_cyc == 0) first_done_cyc = cyc;
    prev_valid = ifc.o_wire_data_valid;
    prev_acc   = ifc.o_wire_data_valid && ifc.i_wire_data_next;
    if (prev_acc) begin
      chk("pixel", ifc.o_wire_data, exp_pix(acc_cnt));
      got.push_back(ifc.o_wire_data);
      acc_cnt++;
    end
  end

  task automatic pulse_start(logic md, logic [31:0] col, logic [31:0] stp, logic [15:0] wd,
                             logic [31:0] len);
    @(posedge clk); #1;
    mode = md; color = col; step = stp; width = wd; length = len; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_job(logic md, logic [31:0] col, logic [31:0] stp, logic [15:0] wd,
                         logic [31:0] len, bit rnd);
    m_mode = md; m_color = col; m_step = stp; m_width = int'(wd); m_len = int'(len);
    acc_cnt = 0; cyc = 0; first_valid_cyc = 0; first_done_cyc = 0;
    prev_valid = 0; prev_acc = 0; got.delete(); rnd_next = rnd;
    pulse_start(md, col, stp, wd, len);
    chk_en = 1;
    want = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int t = 0; t < 3000 && acc_cnt < m_len; t++) begin
      @(posedge clk); #1;
      want = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (acc_cnt < m_len) chk("job_timeout", acc_cnt, m_len);
    repeat (3) @(posedge clk);
    #1;
    chk_en = 0;
    want = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // reset state
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_etype", {30'd0, etype}, 32'd0);
    chk("rst_valid", {31'd0, ifc.o_wire_data_valid}, 32'd0);
    chk("rst_data", ifc.o_wire_data, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // solid fill, consumer always ready
    run_job(1'b0, 32'hFF00FF00, 32'h0, 16'd0, 32'd20, 0);
    chk("solid_count", got.size(), 32'd20);
    chk("solid_word0", got[0], 32'hFF00FF00);
    chk("solid_first_valid_cyc", first_valid_cyc, 32'd2);
    chk("solid_done_cyc", first_done_cyc, 32'd22);

    // gradient with row wrap, started from DONE
    run_job(1'b1, 32'h00000010, 32'h00000105, 16'd4, 32'd10, 0);
    chk("grad_count", got.size(), 32'd10);
    chk("grad0", {16'd0, got[0][15:0]}, 32'h0010);
    chk("grad1", {16'd0, got[1][15:0]}, 32'h0115);
    chk("grad2", {16'd0, got[2][15:0]}, 32'h021A);
    chk("grad3", {16'd0, got[3][15:0]}, 32'h031F);
    chk("grad4_wrap", {16'd0, got[4][15:0]}, 32'h0010);

    // byte channel wraps mod 256 without carry into byte1
    run_job(1'b1, 32'h00000020, 32'h000000F0, 16'd8, 32'd4, 0);
    chk("wrap1", got[1], 32'h00000010);
    chk("wrap2", got[2], 32'h00000000);
    chk("wrap3", got[3], 32'h000000F0);

    // random backpressure, every pixel distinct within a row
    run_job(1'b1, 32'h01020304, 32'h01010101, 16'd100, 32'd100, 1);
    chk("bp_count", got.size(), 32'd100);

    // bad parameters
    pulse_start(1'b0, 32'h1, 32'h0, 16'd5, 32'd0);
    chk("zero_len_err", {31'd0, error}, 32'd1);
    chk("zero_len_type", {30'd0, etype}, 32'd1);
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    chk("abort_clr_err", {31'd0, error}, 32'd0);
    chk("abort_clr_type", {30'd0, etype}, 32'd0);
    pulse_start(1'b1, 32'h1, 32'h0, 16'd0, 32'd5);
    chk("zero_width_type", {30'd0, etype}, 32'd2);
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;

    // next while FIFO empty during RUN
    pulse_start(1'b0, 32'h12345678, 32'h0, 16'd0, 32'd10);
    force_next = 1'b1;
    @(posedge clk); #1; force_next = 1'b0;
    chk("misuse_err", {31'd0, error}, 32'd1);
    chk("misuse_type", {30'd0, etype}, 32'd3);
    chk("misuse_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("misuse_valid", {31'd0, ifc.o_wire_data_valid}, 32'd0);
    chk("misuse_sticky", {31'd0, error}, 32'd1);
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;

    // abort after 5 accepts; a start mid-run must be ignored
    pulse_start(1'b0, 32'hA5A5A5A5, 32'h0, 16'd0, 32'd50);
    want = 1'b1;
    n = 0;
    for (int t = 0; t < 100 && n < 5; t++) begin
      @(negedge clk);
      if (t == 2) start = 1'b0;
      if (ifc.o_wire_data_valid && ifc.i_wire_data_next) begin
        chk("abort_job_pix", ifc.o_wire_data, 32'hA5A5A5A5);
        n++;
      end
      if (t == 1) begin
        length = 32'd3; color = 32'h33333333; start = 1'b1;
      end
    end
    start = 1'b0;
    chk("abort_accepts", n, 32'd5);
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; want = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_valid", {31'd0, ifc.o_wire_data_valid}, 32'd0);
    chk("abort_data", ifc.o_wire_data, 32'd0);
    run_job(1'b0, 32'h0BADF00D, 32'h0, 16'd0, 32'd3, 0);
    chk("fresh_count", got.size(), 32'd3);

    // asynchronous reset while draining
    pulse_start(1'b0, 32'hCAFE0001, 32'h0, 16'd0, 32'd6);
    repeat (8) @(negedge clk);
    chk("drain_busy", {31'd0, busy}, 32'd1);
    chk("drain_head", ifc.o_wire_data, 32'hCAFE0001);
    #2 rstn = 1'b0;
    #1;
    chk("ares_busy", {31'd0, busy}, 32'd0);
    chk("ares_valid", {31'd0, ifc.o_wire_data_valid}, 32'd0);
    chk("ares_data", ifc.o_wire_data, 32'd0);
    chk("ares_flags", {29'd0, done, error, 1'b0} | {30'd0, etype}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
